// File: rtl/shiftreg_ctrl_if.sv
// Byte handshake between the core logic and shiftreg_ctrl: tx byte in, rx byte out.
interface shiftreg_ctrl_if #(
    parameter int NBITS = 8
);
    logic [NBITS-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [NBITS-1:0] rx_data;
    logic             rx_valid;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, rx_data, rx_valid
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, rx_data, rx_valid
    );
endinterface

// File: rtl/shiftreg_ctrl.sv
// Byte-transfer sequencer for an 8-bit parallel-load serial shift register.
// Define SHIFTREG_CTRL_LATCH_EN to add the sr_latch output and a LATCH phase before DONE.
module shiftreg_ctrl #(
    parameter int CLK_DIV = 4,
    parameter int NBITS   = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    shiftreg_ctrl_if.slave   bus,
    output logic             o_busy,
    output logic             o_sr_clk,
    output logic             o_sr_ld,
    output logic [NBITS-1:0] o_sr_data,
`ifdef SHIFTREG_CTRL_LATCH_EN
    output logic             o_sr_latch,
`endif
    input  logic             i_sr_ser
);

    generate
        if (CLK_DIV < 1) begin : g_bad_clk_div
            $error("shiftreg_ctrl: CLK_DIV must be >= 1");
        end
    endgenerate

    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam int BIT_W = $clog2(NBITS) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS);

`ifdef SHIFTREG_CTRL_LATCH_EN
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_LATCH, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;
`endif

    state_t             r_state;
    logic [DIV_W-1:0]   r_div;
    logic [BIT_W-1:0]   r_bit;
    logic [NBITS-1:0]   r_rx_shift;
    logic [NBITS-1:0]   r_rx_data;
    logic [NBITS-1:0]   r_sr_data;
    logic               r_rx_valid;
    logic               r_tx_ready;
    logic               r_busy;
    logic               r_sr_clk;
    logic               r_sr_ld;
`ifdef SHIFTREG_CTRL_LATCH_EN
    logic               r_sr_latch;
`endif
    logic               w_accept;
    logic               w_div_end;

    // tx_ready is only ever high in IDLE, so it alone qualifies the accept.
    assign w_accept  = r_tx_ready && bus.tx_valid;
    assign w_div_end = (r_div == DIV_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_div      <= '0;
            r_bit      <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_sr_data  <= '0;
            r_rx_valid <= 1'b0;
            r_tx_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_sr_clk   <= 1'b0;
            r_sr_ld    <= 1'b0;
`ifdef SHIFTREG_CTRL_LATCH_EN
            r_sr_latch <= 1'b0;
`endif
        end else begin
            r_rx_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sr_data  <= bus.tx_data;
                        r_sr_ld    <= 1'b1;
                        r_tx_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_div      <= '0;
                        r_bit      <= '0;
                        r_state    <= S_LOAD;
                    end else begin
                        r_tx_ready <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (w_div_end) begin
                        r_div    <= '0;
                        r_sr_ld  <= 1'b0;
                        r_sr_clk <= 1'b1;
                        r_state  <= S_SHIFT;
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                S_SHIFT: begin
                    if (!w_div_end) begin
                        r_div <= r_div + DIV_W'(1);
                    end else begin
                        r_div <= '0;
                        // Sample on the falling edge; the register updates its output on the rise.
                        if (r_sr_clk) begin
                            r_sr_clk   <= 1'b0;
                            r_rx_shift <= {r_rx_shift[NBITS-2:0], i_sr_ser};
                            r_bit      <= r_bit + BIT_W'(1);
                        end else if (r_bit == BIT_LAST) begin
`ifdef SHIFTREG_CTRL_LATCH_EN
                            r_sr_latch <= 1'b1;
                            r_state    <= S_LATCH;
`else
                            r_rx_data  <= r_rx_shift;
                            r_rx_valid <= 1'b1;
                            r_state    <= S_DONE;
`endif
                        end else begin
                            r_sr_clk <= 1'b1;
                        end
                    end
                end
`ifdef SHIFTREG_CTRL_LATCH_EN
                S_LATCH: begin
                    if (w_div_end) begin
                        r_div      <= '0;
                        r_sr_latch <= 1'b0;
                        r_rx_data  <= r_rx_shift;
                        r_rx_valid <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
`endif
                S_DONE: begin
                    r_busy     <= 1'b0;
                    r_tx_ready <= 1'b1;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.tx_ready = r_tx_ready;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;
    assign o_busy       = r_busy;
    assign o_sr_clk     = r_sr_clk;
    assign o_sr_ld      = r_sr_ld;
    assign o_sr_data    = r_sr_data;
`ifdef SHIFTREG_CTRL_LATCH_EN
    assign o_sr_latch   = r_sr_latch;
`endif

endmodule
